// File: rtl/coldata_i2c_pkg.sv
// Shared definitions for the COLDATA I2C AXI4-Lite register block.
// Holds the AXI response codes and the byte-address to register-index
// conversion used by both the write and the read paths.
package coldata_i2c_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Drops the byte-lane bits of an AXI byte address; lsb = log2(bytes/word).
  function automatic int unsigned addr_to_idx(input logic [63:0] addr,
                                              input int unsigned lsb);
    return 32'(addr >> lsb);
  endfunction

endpackage

// File: rtl/coldata_i2c_axil_hold.sv
// One-entry holding buffer for an AXI4-Lite request channel (AW or W).
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   valid_i     channel VALID from the master
//   data_i      channel payload
//   block_i     refuses new payload (a write response is outstanding)
//   clear_i     empties the entry (write response handshake)
//   ready_o     channel READY back to the master
//   have_o      payload available this cycle (held, or arriving now)
//   data_o      held payload, or the arriving payload when empty
module coldata_i2c_axil_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  input  logic         block_i,
  input  logic         clear_i,
  output logic         ready_o,
  output logic         have_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         hs;

  assign ready_o = !rst && !full_q && !block_i;
  assign hs      = valid_i && ready_o;
  // Forwarding the arriving payload lets the write commit on the same
  // edge as the handshake that completes it.
  assign have_o  = full_q || hs;
  assign data_o  = full_q ? data_q : data_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear_i) begin
      full_d = 1'b0;
    end else if (hs) begin
      full_d = 1'b1;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
    data_q <= data_d;
  end

endmodule

// File: rtl/coldata_i2c_regs.sv
// AXI4-Lite slave register file: NUM_RW control registers followed by
// NUM_RO status registers, one DATA_W-wide register per word address.
// Ports:
//   ACLK, ARESET       clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*    AXI4-Lite write channels
//   S_AXI_AR*/R*       AXI4-Lite read channels
//   ctrl_o             RW register contents, register i at [i*DATA_W +: DATA_W]
//   status_i           RO register sources, same packing
//   wr_pulse_o         one-cycle strobe per RW register on each committed write
module coldata_i2c_regs
  import coldata_i2c_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter int                NUM_RW    = 8,
  parameter int                NUM_RO    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_W-1:0]        S_AXI_AWADDR,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_W-1:0]        S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]      S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_W-1:0]        S_AXI_ARADDR,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_W-1:0]        S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_RW*DATA_W-1:0] ctrl_o,
  input  logic [NUM_RO*DATA_W-1:0] status_i,
  output logic [NUM_RW-1:0]        wr_pulse_o
);

  localparam int          STRB_W = DATA_W / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);

  logic [DATA_W-1:0] regs_q [NUM_RW];
  logic [DATA_W-1:0] regs_d [NUM_RW];
  logic [NUM_RW-1:0] pulse_q, pulse_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              aw_have, w_have, commit, b_hs, ar_hs;
  logic [ADDR_W-1:0] aw_addr;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  int unsigned       w_idx, r_idx;

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  coldata_i2c_axil_hold #(.W(ADDR_W)) u_aw_hold (
    .clk     (ACLK),
    .rst     (ARESET),
    .valid_i (S_AXI_AWVALID),
    .data_i  (S_AXI_AWADDR),
    .block_i (bvalid_q),
    .clear_i (b_hs),
    .ready_o (S_AXI_AWREADY),
    .have_o  (aw_have),
    .data_o  (aw_addr)
  );

  coldata_i2c_axil_hold #(.W(DATA_W + STRB_W)) u_w_hold (
    .clk     (ACLK),
    .rst     (ARESET),
    .valid_i (S_AXI_WVALID),
    .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .block_i (bvalid_q),
    .clear_i (b_hs),
    .ready_o (S_AXI_WREADY),
    .have_o  (w_have),
    .data_o  ({w_strb, w_data})
  );

  // Both holds stay full while BVALID is up; the bvalid_q guard keeps that
  // from re-committing the same write every cycle.
  assign commit = aw_have && w_have && !bvalid_q;
  assign b_hs   = bvalid_q && S_AXI_BREADY;
  assign w_idx  = addr_to_idx(64'(aw_addr), LSB);
  assign r_idx  = addr_to_idx(64'(S_AXI_ARADDR), LSB);

  assign S_AXI_ARREADY = !rvalid_q && !ARESET;
  assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    regs_d   = regs_q;
    pulse_d  = '0;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (w_idx == unsigned'(i)) begin
          regs_d[i]  = apply_strb(regs_q[i], w_data, w_strb);
          pulse_d[i] = 1'b1;
          bresp_d    = RESP_OKAY;
        end
      end
    end else if (b_hs) begin
      bvalid_d = 1'b0;
    end
  end

  // Reads take regs_q, so a same-edge write is not visible yet.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      for (int i = 0; i < NUM_RW; i++) begin
        if (r_idx == unsigned'(i)) begin
          rdata_d = regs_q[i];
          rresp_d = RESP_OKAY;
        end
      end
      for (int j = 0; j < NUM_RO; j++) begin
        if (r_idx == unsigned'(NUM_RW + j)) begin
          rdata_d = status_i[j*DATA_W +: DATA_W];
          rresp_d = RESP_OKAY;
        end
      end
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_RW; i++) regs_q[i] <= RESET_VAL;
      pulse_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    ctrl_o = '0;
    for (int i = 0; i < NUM_RW; i++) ctrl_o[i*DATA_W +: DATA_W] = regs_q[i];
  end

  assign wr_pulse_o   = pulse_q;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;

endmodule

// File: tb/tb_coldata_i2c_regs.sv
// Self-checking bench for coldata_i2c_regs (default parameters).
module tb_coldata_i2c_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   awaddr;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [7:0]   araddr;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic [255:0] ctrl;
  logic [127:0] status;
  logic [7:0]   pulse;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mregs [8];

  always #5 clk = ~clk;

  coldata_i2c_regs dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl_o(ctrl), .status_i(status), .wr_pulse_o(pulse)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ctrl(input string tag);
    for (int i = 0; i < 8; i++) check(tag, ctrl[i*32 +: 32], mregs[i]);
  endtask

  // Reference: word index = addr/4, 0..7 RW, 8..11 RO, rest out of range.
  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int idx, cyc;
    logic aw_done, w_done, aw_hs, w_hs;
    logic [1:0] eresp;
    logic [7:0] epulse;
    idx    = int'(addr) / 4;
    eresp  = (idx < 8) ? 2'b00 : 2'b10;
    epulse = (idx < 8) ? 8'(1 << idx) : 8'h00;
    awaddr = addr; wdata = data; wstrb = strb;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (aw_done) check("awready_while_held", awready, 0);
      if (w_done)  check("wready_while_held", wready, 0);
      check("bvalid_before_commit", bvalid, 0);
      awvalid = !aw_done && (cyc >= aw_dly);
      wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      cyc++;
      if (aw_hs) aw_done = 1'b1;
      if (w_hs)  w_done = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      check("write_handshake_timeout", 0, 1);
      return;
    end
    if (idx < 8) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mregs[idx][b*8 +: 8] = data[b*8 +: 8];
    end
    check("bvalid_on_commit", bvalid, 1);
    check("bresp", bresp, eresp);
    check("wr_pulse", pulse, epulse);
    check_ctrl("ctrl_after_write");
    for (int k = 0; k < b_dly; k++) begin
      bready = 1'b0;
      tick();
      check("bvalid_stall", bvalid, 1);
      check("bresp_stall", bresp, eresp);
      check("awready_stall", awready, 0);
      check("wready_stall", wready, 0);
      check("wr_pulse_after", pulse, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bvalid_cleared", bvalid, 0);
    check("wr_pulse_cleared", pulse, 0);
    check("awready_idle", awready, 1);
    check("wready_idle", wready, 1);
    check_ctrl("ctrl_stable");
  endtask

  task automatic do_read(input logic [7:0] addr, input int r_dly);
    int idx, cyc;
    logic hs;
    logic [31:0] edata;
    logic [1:0]  eresp;
    idx = int'(addr) / 4;
    if (idx < 8) begin
      edata = mregs[idx]; eresp = 2'b00;
    end else if (idx < 12) begin
      edata = status[(idx-8)*32 +: 32]; eresp = 2'b00;
    end else begin
      edata = 32'h0; eresp = 2'b10;
    end
    araddr = addr; hs = 1'b0; cyc = 0;
    while (!hs && cyc < 20) begin
      arvalid = 1'b1;
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    if (!hs) begin
      check("read_handshake_timeout", 0, 1);
      return;
    end
    check("rvalid", rvalid, 1);
    check("rdata", rdata, edata);
    check("rresp", rresp, eresp);
    for (int k = 0; k < r_dly; k++) begin
      rready = 1'b0;
      tick();
      check("rvalid_stall", rvalid, 1);
      check("rdata_stall", rdata, edata);
      check("arready_stall", arready, 0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rvalid_cleared", rvalid, 0);
    check("arready_idle", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oldv, newv;
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; status = '0;
    for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
    repeat (3) tick();
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_arready", arready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_pulse", pulse, 0);
    check_ctrl("rst_ctrl");
    rst = 1'b0;
    #1;
    check("post_rst_awready", awready, 1);
    check("post_rst_wready", wready, 1);
    check("post_rst_arready", arready, 1);
    tick();

    // Basic writes and readback.
    for (int i = 0; i < 4; i++) do_write(8'(i*4), 32'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(8'(i*4), 0);

    // Data leads address by three cycles.
    do_write(8'h10, 32'hCAFE0010, 4'hF, 3, 0, 0);

    // Byte strobes.
    do_write(8'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(8'h08, 32'h11223344, 4'b0101, 0, 0, 0);
    check("strobe_merge", ctrl[2*32 +: 32], 32'hAA22CC44);
    do_write(8'h14, 32'h12345678, 4'h0, 1, 0, 1);

    // RO and out-of-range accesses.
    status[31:0] = 32'h00005A5A;
    do_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    do_write(8'h40, 32'hFFFFFFFF, 4'hF, 0, 2, 0);
    do_read(8'h40, 0);
    do_read(8'h20, 0);

    // Back-pressure on B and R.
    do_write(8'h18, 32'h0BADBEEF, 4'hF, 0, 0, 5);
    do_read(8'h18, 5);

    // Read and write of the same register on the same edge.
    oldv = mregs[3]; newv = 32'hDEAD0003;
    awaddr = 8'h0C; wdata = newv; wstrb = 4'hF; araddr = 8'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    mregs[3] = newv;
    check("rw_same_edge_rdata", rdata, oldv);
    check("rw_same_edge_rvalid", rvalid, 1);
    check("rw_same_edge_bvalid", bvalid, 1);
    check("rw_same_edge_ctrl", ctrl[3*32 +: 32], newv);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    check("rw_same_edge_done", {bvalid, rvalid}, 2'b00);

    // Reset after AW accepted, before W.
    awaddr = 8'h04; awvalid = 1;
    check("aw_only_ready", awready, 1);
    tick();
    awvalid = 0;
    check("aw_only_awready", awready, 0);
    rst = 1; wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1;
    tick();
    tick();
    check("midrst_awready", awready, 0);
    check("midrst_wready", wready, 0);
    check("midrst_arready", arready, 0);
    check("midrst_bvalid", bvalid, 0);
    wvalid = 0;
    rst = 0;
    for (int i = 0; i < 8; i++) mregs[i] = 32'h0;
    #1;
    check("midrst_release_awready", awready, 1);
    check("midrst_release_wready", wready, 1);
    check("midrst_release_arready", arready, 1);
    check_ctrl("midrst_ctrl");
    tick();
    check("midrst_no_commit_bvalid", bvalid, 0);
    check("midrst_no_pulse", pulse, 0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        status = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/coldata_i2c_regs.md
COLDATA_I2C_REGS -- requirements
Module: coldata_i2c_regs

Interface
REQ-001 SHALL have parameter DATA_W, default 32, AXI4-Lite data width (32 or 64).
REQ-002 SHALL have parameter ADDR_W, default 8, AXI4-Lite byte address width.
REQ-003 SHALL have parameter NUM_RW, default 8, number of read/write control registers (indices 0..NUM_RW-1).
REQ-004 SHALL have parameter NUM_RO, default 4, number of read-only status registers (indices NUM_RW..NUM_RW+NUM_RO-1).
REQ-005 SHALL have parameter RESET_VAL, default 0, reset value of every RW register.
REQ-006 SHALL have port ACLK  in  1  single clock; every port is synchronous to it.
REQ-007 SHALL have port ARESET  in  1  reset, synchronous and active-high.
REQ-008 SHALL have ports S_AXI_AWADDR in ADDR_W; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1: write address channel.
REQ-009 SHALL have ports S_AXI_WDATA in DATA_W; S_AXI_WSTRB in DATA_W/8; S_AXI_WVALID in 1; S_AXI_WREADY out 1: write data channel.
REQ-010 SHALL have ports S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1: write response channel.
REQ-011 SHALL have ports S_AXI_ARADDR in ADDR_W; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1: read address channel.
REQ-012 SHALL have ports S_AXI_RDATA out DATA_W; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1: read data channel.
REQ-013 SHALL have port ctrl_o  out  NUM_RW*DATA_W  flattened RW register contents, register i at bits [i*DATA_W +: DATA_W].
REQ-014 SHALL have port status_i  in  NUM_RO*DATA_W  flattened RO register sources.
REQ-015 SHALL have port wr_pulse_o  out  NUM_RW  one-cycle pulse per RW register on a committed write.

Function
REQ-016 Register index SHALL be ADDR[ADDR_W-1:log2(DATA_W/8)]. Low address bits SHALL be ignored.
REQ-017 AW and W SHALL be accepted independently, each into a one-entry hold. READY for a channel SHALL be high when its hold is empty and BVALID is low.
REQ-018 The write SHALL commit on the edge where both holds are full, including the same edge as either handshake. BVALID SHALL rise on that edge.
REQ-019 With AW and W both valid at cycle 0 from idle, ctrl_o and BVALID SHALL update at cycle 1.
REQ-020 Commit SHALL apply WSTRB per byte. Unstrobed bytes SHALL keep their value.
REQ-021 A commit to RW index i SHALL drive wr_pulse_o[i] high for exactly one cycle, coincident with BVALID rising. The pulse SHALL occur even with WSTRB=0.
REQ-022 A write to an RO index or to an index >= NUM_RW+NUM_RO SHALL change no register, SHALL emit no pulse, and SHALL respond with BRESP=SLVERR (2'b10). Otherwise BRESP SHALL be OKAY (2'b00).
REQ-023 BVALID SHALL hold until BREADY. The holds SHALL clear on the B handshake, so no new AW/W is accepted while BVALID is high.
REQ-024 ARREADY SHALL equal !RVALID.
REQ-025 On the AR handshake edge, RDATA, RRESP and RVALID SHALL load, giving 1-cycle latency. RDATA and RRESP SHALL be held stable until RREADY.
REQ-026 Read data SHALL be: RW registers from the register; RO registers from status_i sampled on the AR edge; out-of-range as 0 with RRESP=SLVERR.
REQ-027 A read and a write commit to the same register on the same edge SHALL return the pre-write value.
REQ-028 The read and write paths SHALL operate concurrently without mutual stalls.

Reset
REQ-029 While ARESET=1: RW registers = RESET_VAL; holds empty; BVALID=0; RVALID=0; BRESP=0; RRESP=0; RDATA=0; wr_pulse_o=0.
REQ-030 While ARESET=1: AWREADY, WREADY and ARREADY SHALL be 0. They SHALL be 1 on the first cycle after ARESET falls.
REQ-031 Reset mid-transaction SHALL discard pending AW/W/B/R state without committing the write.

Structure
REQ-032 Package coldata_i2c_pkg SHALL hold the RESP_OKAY and RESP_SLVERR constants and the address-to-index function.
REQ-033 The one-entry channel hold SHALL be sub-module coldata_i2c_axil_hold, instantiated for AW and W.

Verification
REQ-034 Defaults: write 0x00000001..0x00000004 to addresses 0x00, 0x04, 0x08, 0x0C; read back -> equal data, RRESP=OKAY, wr_pulse_o[0..3] each pulsed once.
REQ-035 WDATA presented 3 cycles before AWADDR 0x10 -> single commit on the AW edge, BVALID the next cycle, reg4 = data.
REQ-036 reg2=0xAABBCCDD; write 0x11223344 with WSTRB=4'b0101 -> reg2 = 0xAA22CC44.
REQ-037 Write to 0x20 (RO index 8) and to 0x40 (index 16) -> BRESP=SLVERR, ctrl_o unchanged; read 0x40 -> RDATA=0, RRESP=SLVERR; read 0x20 with status_i[0]=0x5A5A -> RDATA=0x5A5A.
REQ-038 Hold BREADY and RREADY low 5 cycles -> BVALID, RVALID and RDATA stable; AWREADY, WREADY and ARREADY stay 0.
REQ-039 Assert ARESET after AW is accepted but before W -> no commit; all registers = RESET_VAL; readies = 1 the cycle after release.
